// File: rtl/present_pkg.sv
// +----------------------------------------------------------------------------+
// | present_pkg: PRESENT-80 constants, S-box tables, key-schedule helpers.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package present_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int ROUNDS  = 31;
  localparam int CTR_W   = 5;

  // Nibble n of each table lives at bits [4n+3:4n].
  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic logic [3:0] sbox_nib(input logic [3:0] n);
    return SBOX[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv_nib(input logic [3:0] n);
    return SBOX_INV[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [BLOCK_W-1:0] sbox_layer_inv(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = sbox_inv_nib(s[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] key_fwd_update(input logic [KEY_W-1:0] k,
                                                      input logic [CTR_W-1:0] ctr);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox_nib(r[79:76]);
    r[19:15]   = r[19:15] ^ ctr;
    return r;
  endfunction

  // Exact reverse of key_fwd_update, so steps run in the opposite order.
  function automatic logic [KEY_W-1:0] key_inv_update(input logic [KEY_W-1:0] k,
                                                      input logic [CTR_W-1:0] ctr);
    logic [KEY_W-1:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ ctr;
    r[79:76]   = sbox_inv_nib(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/present_player_inv.sv
// +----------------------------------------------------------------------------+
// | present_player_inv: inverse PRESENT bit permutation, out[i] = in[P(i)].    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module present_player_inv
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] in_data,
  output logic [BLOCK_W-1:0] out_data
);

  generate
    for (genvar i = 0; i < 63; i++) begin : g_bit
      assign out_data[i] = in_data[(16 * i) % 63];
    end
  endgenerate

  assign out_data[63] = in_data[63];

endmodule

`default_nettype wire

// File: rtl/present_decrypt_core.sv
// +----------------------------------------------------------------------------+
// | present_decrypt_core: iterative PRESENT-80 decryptor, one round per cycle. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module present_decrypt_core
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_cipher,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_plain,
  output logic               busy
);

  localparam logic [CTR_W-1:0] CTR_FIRST = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_LAST  = CTR_W'(ROUNDS);

  state_e             fsm_q, fsm_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [BLOCK_W-1:0] out_plain_q, out_plain_d;

  logic [BLOCK_W-1:0] perm_in;
  logic [BLOCK_W-1:0] perm_out;
  logic [BLOCK_W-1:0] round_out;
  logic [KEY_W-1:0]   key_prev;

  assign perm_in   = state_q ^ key_q[79:16];
  assign round_out = sbox_layer_inv(perm_out);
  assign key_prev  = key_inv_update(key_q, ctr_q);

  present_player_inv u_player_inv (
    .in_data  (perm_in),
    .out_data (perm_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      key_q       <= '0;
      ctr_q       <= '0;
      out_plain_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      ctr_q       <= ctr_d;
      out_plain_q <= out_plain_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    key_d       = key_q;
    ctr_d       = ctr_q;
    out_plain_d = out_plain_q;

    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_cipher;
          key_d   = in_key;
          ctr_d   = CTR_FIRST;
          fsm_d   = KEYEXP;
        end
      end

      // Walk the schedule forward so key_q ends as the last round key.
      KEYEXP: begin
        key_d = key_fwd_update(key_q, ctr_q);
        if (ctr_q == CTR_LAST) begin
          fsm_d = ROUND;
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end

      ROUND: begin
        key_d = key_prev;
        if (ctr_q == CTR_FIRST) begin
          // key_prev is K1 here: the final whitening key.
          out_plain_d = round_out ^ key_prev[79:16];
          fsm_d       = DONE;
        end else begin
          state_d = round_out;
          ctr_d   = ctr_q - CTR_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end

      default: fsm_d = IDLE;
    endcase
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == KEYEXP) || (fsm_q == ROUND);
  assign out_plain = out_plain_q;

endmodule

`default_nettype wire

// File: tb/tb_present_decrypt_core.sv
// +----------------------------------------------------------------------------+
// | tb_present_decrypt_core: scoreboard bench for the PRESENT-80 decryptor.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_present_decrypt_core;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_cipher;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_plain;
  logic        busy;

  logic [63:0] pinv_in;
  logic [63:0] pinv_out;

  int          n_vec;
  int          n_err;
  logic [63:0] exp_q[$];

  present_decrypt_core dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cipher (in_cipher),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_plain (out_plain),
    .busy      (busy)
  );

  present_player_inv u_pinv (
    .in_data  (pinv_in),
    .out_data (pinv_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  // Reference encryptor, used to build fresh ciphertext/plaintext pairs.
  function automatic logic [3:0] ref_sbox(input logic [3:0] n);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;
    return tbl[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] ref_player(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) r[(16 * i) % 63] = s[i];
    r[63] = s[63];
    return r;
  endfunction

  function automatic logic [63:0] ref_encrypt(input logic [63:0] p, input logic [79:0] k);
    logic [63:0] s;
    logic [79:0] kk;
    s  = p;
    kk = k;
    for (int i = 1; i <= 31; i++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = ref_sbox(s[4*n +: 4]);
      s = ref_player(s);
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = ref_sbox(kk[79:76]);
      kk[19:15] = kk[19:15] ^ 5'(i);
    end
    return s ^ kk[79:16];
  endfunction

  task automatic send(input logic [79:0] k, input logic [63:0] c,
                      input logic [63:0] expv, input bit push);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_val("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_key    = k;
    in_cipher = c;
    if (push) exp_q.push_back(expv);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic recv(input int hold, input bit chk_lat);
    int          cyc;
    logic [63:0] expv;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!out_valid && cyc < 200);
    if (chk_lat) check_val("latency", 64'(cyc), 64'd62);
    check_val("out_valid_seen", 64'(out_valid), 64'd1);
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 64'(exp_q.size()), 64'd1);
      expv = '0;
    end else begin
      expv = exp_q.pop_front();
    end
    check_val("plain", out_plain, expv);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_val("hold_valid", 64'(out_valid), 64'd1);
      check_val("hold_plain", out_plain, expv);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val("idle_after_ack", 64'(in_ready), 64'd1);
    check_val("valid_drop", 64'(out_valid), 64'd0);
    check_val("plain_kept", out_plain, expv);
  endtask

  initial begin
    logic [79:0] rk;
    logic [63:0] rp;
    logic [63:0] oh;

    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_cipher = '0;
    in_key    = '0;
    out_ready = 1'b0;
    pinv_in   = '0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_plain", out_plain, 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;

    // Published vectors.
    send(80'h0, 64'h5579C1387B228445, 64'h0, 1'b1);
    recv(0, 1'b1);
    send({80{1'b1}}, 64'hE72C46C0F5945049, 64'h0, 1'b1);
    recv(0, 1'b1);
    send({80{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}}, 1'b1);
    recv(0, 1'b1);

    // Consumer stalls for 10 cycles.
    send(80'h0, 64'hA112FFC72F68417B, {64{1'b1}}, 1'b1);
    recv(10, 1'b1);

    // Early out_ready while computing has no effect.
    send(80'h0, 64'h5579C1387B228445, 64'h0, 1'b1);
    out_ready = 1'b1;
    recv(0, 1'b1);

    // Extra in_valid during ROUND must be ignored.
    send(80'h0, 64'h5579C1387B228445, 64'h0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_cipher = 64'hA112FFC72F68417B;
    check_val("in_ready_round", 64'(in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    recv(0, 1'b0);

    // Abort at ROUND ctr==15 (47 edges after accept).
    send(80'h0, 64'hA112FFC72F68417B, 64'h0, 1'b0);
    repeat (47) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_val("abort_out_valid", 64'(out_valid), 64'd0);
    check_val("abort_in_ready", 64'(in_ready), 64'd1);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_out_plain", out_plain, 64'd0);
    reset = 1'b1;
    send(80'h0, 64'h5579C1387B228445, 64'h0, 1'b1);
    recv(0, 1'b1);

    // Random pairs built with the reference encryptor.
    for (int v = 0; v < 4; v++) begin
      rk = {16'($urandom), $urandom, $urandom};
      rp = {$urandom, $urandom};
      send(rk, ref_encrypt(rp, rk), rp, 1'b1);
      recv(v, 1'b1);
    end

    // Standalone inverse permutation over all one-hot inputs.
    for (int j = 0; j < 64; j++) begin
      oh      = 64'd1 << j;
      pinv_in = ref_player(oh);
      #1;
      check_val("player_inv", pinv_out, oh);
    end
    rp      = {$urandom, $urandom};
    pinv_in = ref_player(rp);
    #1;
    check_val("player_inv_rand", pinv_out, rp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
